// File: rtl/step_motor_sequencer.sv
// Avalon-MM programmed step pulse generator: linear accel/cruise/decel period ramp,
// absolute position tracking, abort handling and a done interrupt.
module step_motor_sequencer #(
    parameter int unsigned PULSE_W    = 4,
    parameter int unsigned MIN_PERIOD = 16
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic        avs_ctrl_waitrequest,
    output logic        step,
    output logic        forward_back,
    output logic        busy,
    output logic        irq
);

    // Bus handshake: no wait states; a read returns data the cycle after the strobe,
    // and a write in the same cycle as a read takes priority (the read is dropped).

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE_HI = 2'd1,
        ST_PULSE_LO = 2'd2,
        ST_STOP     = 2'd3
    } state_t;

    localparam logic [31:0] PW    = 32'(PULSE_W);
    localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

    state_t      state_q, state_d;
    logic [31:0] steps_q, steps_d;
    logic [31:0] p_start_q, p_start_d;
    logic [31:0] p_cruise_q, p_cruise_d;
    logic [31:0] p_delta_q, p_delta_d;
    logic        dir_q, dir_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic [31:0] position_q, position_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] readdata_q, readdata_d;
    logic        fb_q, fb_d;
    logic [31:0] mv_start_q, mv_start_d;
    logic [31:0] mv_cruise_q, mv_cruise_d;
    logic [31:0] mv_delta_q, mv_delta_d;
    logic [31:0] cur_q, cur_d;
    logic [31:0] ramp_q, ramp_d;
    logic [31:0] cnt_q, cnt_d;

    logic        wr_ctrl, ctrl_start, ctrl_abort;
    logic [31:0] p_start_eff, p_cruise_floor, cruise_eff;
    logic [32:0] sum33;
    logic [31:0] dec_period, sub_period, acc_period;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign p_start_eff    = (p_start_q < MIN_P) ? MIN_P : p_start_q;
    assign p_cruise_floor = (p_cruise_q < MIN_P) ? MIN_P : p_cruise_q;
    assign cruise_eff     = (p_cruise_floor > p_start_eff) ? p_start_eff : p_cruise_floor;

    // Ramp candidates, saturating in both directions against the latched move limits.
    assign sum33      = {1'b0, cur_q} + {1'b0, mv_delta_q};
    assign dec_period = (sum33 > {1'b0, mv_start_q}) ? mv_start_q : sum33[31:0];
    assign sub_period = (mv_delta_q >= cur_q) ? 32'd0 : (cur_q - mv_delta_q);
    assign acc_period = (sub_period < mv_cruise_q) ? mv_cruise_q : sub_period;

    assign wr_ctrl    = avs_ctrl_write && (avs_ctrl_address == 3'd4) && avs_ctrl_byteenable[0];
    assign ctrl_start = wr_ctrl && avs_ctrl_writedata[0];
    assign ctrl_abort = wr_ctrl && avs_ctrl_writedata[2];

    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        p_start_d   = p_start_q;
        p_cruise_d  = p_cruise_q;
        p_delta_d   = p_delta_q;
        dir_d       = dir_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        position_d  = position_q;
        remaining_d = remaining_q;
        readdata_d  = readdata_q;
        fb_d        = fb_q;
        mv_start_d  = mv_start_q;
        mv_cruise_d = mv_cruise_q;
        mv_delta_d  = mv_delta_q;
        cur_d       = cur_q;
        ramp_d      = ramp_q;
        cnt_d       = cnt_q;

        if (avs_ctrl_write) begin
            case (avs_ctrl_address)
                3'd0: steps_d    = be_merge(steps_q, avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd1: p_start_d  = be_merge(p_start_q, avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd2: p_cruise_d = be_merge(p_cruise_q, avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd3: p_delta_d  = be_merge(p_delta_q, avs_ctrl_writedata, avs_ctrl_byteenable);
                3'd4: begin
                    if (avs_ctrl_byteenable[0]) begin
                        dir_d    = avs_ctrl_writedata[1];
                        irq_en_d = avs_ctrl_writedata[3];
                    end
                end
                3'd5: begin
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                end
                3'd6: begin
                    if (state_q == ST_IDLE)
                        position_d = be_merge(position_q, avs_ctrl_writedata, avs_ctrl_byteenable);
                end
                default: ;
            endcase
        end else if (avs_ctrl_read) begin
            case (avs_ctrl_address)
                3'd0:    readdata_d = steps_q;
                3'd1:    readdata_d = p_start_q;
                3'd2:    readdata_d = p_cruise_q;
                3'd3:    readdata_d = p_delta_q;
                3'd4:    readdata_d = {28'd0, irq_en_q, 1'b0, dir_q, 1'b0};
                3'd5:    readdata_d = {29'd0, aborted_q, done_q, (state_q != ST_IDLE)};
                3'd6:    readdata_d = position_q;
                default: readdata_d = remaining_q;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    fb_d        = avs_ctrl_writedata[1];
                    mv_start_d  = p_start_eff;
                    mv_cruise_d = cruise_eff;
                    mv_delta_d  = p_delta_q;
                    cur_d       = p_start_eff;
                    ramp_d      = 32'd0;
                    done_d      = 1'b0;
                    aborted_d   = 1'b0;
                    if (steps_q == 32'd0) begin
                        done_d      = 1'b1;
                        remaining_d = 32'd0;
                    end else begin
                        // First step's rising edge is emitted on the cycle after the start write.
                        remaining_d = steps_q - 32'd1;
                        position_d  = avs_ctrl_writedata[1] ? position_q + 32'd1
                                                            : position_q - 32'd1;
                        cnt_d       = 32'd0;
                        state_d     = ST_PULSE_HI;
                    end
                end
            end
            ST_PULSE_HI: begin
                cnt_d = cnt_q + 32'd1;
                if (ctrl_abort)
                    state_d = ST_STOP;
                else if (cnt_q == PW - 32'd1)
                    state_d = ST_PULSE_LO;
            end
            ST_PULSE_LO: begin
                cnt_d = cnt_q + 32'd1;
                if (ctrl_abort) begin
                    state_d = ST_STOP;
                end else if (cnt_q == cur_q - 32'd1) begin
                    if (remaining_q == 32'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        if (remaining_q <= ramp_q) begin
                            cur_d  = dec_period;
                            ramp_d = (ramp_q == 32'd0) ? 32'd0 : ramp_q - 32'd1;
                        end else if (cur_q > mv_cruise_q) begin
                            cur_d  = acc_period;
                            ramp_d = ramp_q + 32'd1;
                        end
                        remaining_d = remaining_q - 32'd1;
                        position_d  = fb_q ? position_q + 32'd1 : position_q - 32'd1;
                        cnt_d       = 32'd0;
                        state_d     = ST_PULSE_HI;
                    end
                end
            end
            default: begin
                // STOP: let an in-flight high phase run to full width before going idle.
                cnt_d = cnt_q + 32'd1;
                if (cnt_q >= PW - 32'd1) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            state_q     <= ST_IDLE;
            steps_q     <= 32'd0;
            p_start_q   <= 32'd0;
            p_cruise_q  <= 32'd0;
            p_delta_q   <= 32'd0;
            dir_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            position_q  <= 32'd0;
            remaining_q <= 32'd0;
            readdata_q  <= 32'd0;
            fb_q        <= 1'b0;
            mv_start_q  <= 32'd0;
            mv_cruise_q <= 32'd0;
            mv_delta_q  <= 32'd0;
            cur_q       <= 32'd0;
            ramp_q      <= 32'd0;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            steps_q     <= steps_d;
            p_start_q   <= p_start_d;
            p_cruise_q  <= p_cruise_d;
            p_delta_q   <= p_delta_d;
            dir_q       <= dir_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            position_q  <= position_d;
            remaining_q <= remaining_d;
            readdata_q  <= readdata_d;
            fb_q        <= fb_d;
            mv_start_q  <= mv_start_d;
            mv_cruise_q <= mv_cruise_d;
            mv_delta_q  <= mv_delta_d;
            cur_q       <= cur_d;
            ramp_q      <= ramp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign avs_ctrl_readdata    = readdata_q;
    assign avs_ctrl_waitrequest = 1'b0;
    assign step                 = (state_q == ST_PULSE_HI) || ((state_q == ST_STOP) && (cnt_q < PW));
    assign forward_back         = fb_q;
    assign busy                 = (state_q != ST_IDLE);
    assign irq                  = done_q & irq_en_q;

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Directed bench for step_motor_sequencer: register-access vector table plus
// hand-written move sequences checked against expected step periods.
module tb_step_motor_sequencer;

    localparam int PULSE_W = 4;

    logic        clk;
    logic        rst;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [2:0]  addr;
    logic        wr;
    logic        rd;
    logic        waitreq;
    logic        step;
    logic        fwd;
    logic        busy;
    logic        irq;

    int n_checks;
    int n_fail;

    step_motor_sequencer #(.PULSE_W(PULSE_W), .MIN_PERIOD(16)) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_ctrl_writedata   (wdata),
        .avs_ctrl_readdata    (rdata),
        .avs_ctrl_byteenable  (be),
        .avs_ctrl_address     (addr),
        .avs_ctrl_write       (wr),
        .avs_ctrl_read        (rd),
        .avs_ctrl_waitrequest (waitreq),
        .step                 (step),
        .forward_back         (fwd),
        .busy                 (busy),
        .irq                  (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // step-train monitor, sampled on the falling edge
    int          cyc;
    logic        step_prev;
    logic        busy_prev;
    int          hi_cnt;
    int          busy_fall;
    int          rise_q[$];
    int          hw_q[$];
    logic [31:0] exp_q[$];

    initial begin
        cyc = 0; step_prev = 1'b0; busy_prev = 1'b0; hi_cnt = 0; busy_fall = 0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (step && !step_prev) begin
            rise_q.push_back(cyc);
            hi_cnt = 1;
        end else if (step) begin
            hi_cnt = hi_cnt + 1;
        end
        if (!step && step_prev) hw_q.push_back(hi_cnt);
        if (!busy && busy_prev) busy_fall = cyc;
        step_prev = step;
        busy_prev = busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: act=0x%08h req=0x%08h", name, act, req);
        end
    endtask

    // driver tasks: each is entered just after a rising edge and consumes one cycle
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        wr = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        wr = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        rd = 1'b1; addr = a;
        @(posedge clk); #1;
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] req);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, req);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_rises(input string name, input int count, input int budget);
        int n;
        n = 0;
        while (rise_q.size() < count && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_rise_timeout"}, 32'(rise_q.size()), 32'(count));
    endtask

    task automatic clear_mon();
        rise_q.delete();
        hw_q.delete();
        exp_q.delete();
        busy_fall = 0;
    endtask

    // compares observed rising-edge spacing (last one: rise to busy fall) with exp_q
    task automatic check_move(input string name);
        int act;
        check({name, "_pulse_count"}, 32'(rise_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rise_q.size(); i++) begin
            act = (i + 1 < rise_q.size()) ? rise_q[i+1] - rise_q[i] : busy_fall - rise_q[i];
            check($sformatf("%s_period[%0d]", name, i), 32'(act), exp_q[i]);
            if (i < hw_q.size())
                check($sformatf("%s_width[%0d]", name, i), 32'(hw_q[i]), 32'(PULSE_W));
        end
    endtask

    typedef struct {
        logic        is_wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] req;
    } vec_t;

    vec_t vecs[32];
    int   n_vec;

    task automatic add_vec(input logic is_wr, input logic [2:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic [31:0] req);
        vecs[n_vec].is_wr = is_wr;
        vecs[n_vec].a     = a;
        vecs[n_vec].d     = d;
        vecs[n_vec].b     = b;
        vecs[n_vec].req   = req;
        n_vec++;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_vec = 0;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 3'd0; wdata = 32'd0; be = 4'h0;

        for (int i = 0; i < 8; i++) add_vec(1'b0, 3'(i), 32'd0, 4'h0, 32'd0);
        add_vec(1'b1, 3'd0, 32'hA5A5_1234, 4'hF, 32'd0);
        add_vec(1'b0, 3'd0, 32'd0,         4'h0, 32'hA5A5_1234);
        add_vec(1'b1, 3'd0, 32'hFFFF_FFFF, 4'h2, 32'd0);
        add_vec(1'b0, 3'd0, 32'd0,         4'h0, 32'hA5A5_FF34);
        add_vec(1'b1, 3'd3, 32'h0000_0014, 4'hF, 32'd0);
        add_vec(1'b0, 3'd3, 32'd0,         4'h0, 32'h0000_0014);
        add_vec(1'b1, 3'd4, 32'h0000_000C, 4'h1, 32'd0);
        add_vec(1'b0, 3'd4, 32'd0,         4'h0, 32'h0000_0008);
        add_vec(1'b0, 3'd5, 32'd0,         4'h0, 32'h0000_0000);
        add_vec(1'b1, 3'd6, 32'h8000_0001, 4'hF, 32'd0);
        add_vec(1'b0, 3'd6, 32'd0,         4'h0, 32'h8000_0001);
        add_vec(1'b1, 3'd6, 32'hFFFF_FFFF, 4'h8, 32'd0);
        add_vec(1'b0, 3'd6, 32'd0,         4'h0, 32'hFF00_0001);
        add_vec(1'b1, 3'd7, 32'h0000_0055, 4'hF, 32'd0);
        add_vec(1'b0, 3'd7, 32'd0,         4'h0, 32'h0000_0000);
        add_vec(1'b1, 3'd0, 32'd0,         4'hF, 32'd0);
        add_vec(1'b1, 3'd6, 32'd0,         4'hF, 32'd0);
        add_vec(1'b1, 3'd4, 32'd0,         4'h1, 32'd0);
        add_vec(1'b0, 3'd4, 32'd0,         4'h0, 32'h0000_0000);

        idle_cycles(3);
        rst = 1'b0;
        check("reset_step",    {31'd0, step}, 32'd0);
        check("reset_busy",    {31'd0, busy}, 32'd0);
        check("reset_irq",     {31'd0, irq},  32'd0);
        check("reset_fwd",     {31'd0, fwd},  32'd0);
        check("reset_rdata",   rdata,         32'd0);
        check("waitrequest",   {31'd0, waitreq}, 32'd0);

        for (int i = 0; i < n_vec; i++) begin
            if (vecs[i].is_wr) bus_write(vecs[i].a, vecs[i].d, vecs[i].b);
            else read_check($sformatf("vec[%0d]_addr%0d", i, vecs[i].a), vecs[i].a, vecs[i].req);
        end

        // move 1: constant 20-clock period, forward
        clear_mon();
        bus_write(3'd0, 32'd5, 4'hF);
        bus_write(3'd1, 32'd20, 4'hF);
        bus_write(3'd2, 32'd20, 4'hF);
        bus_write(3'd3, 32'd0, 4'hF);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'd20);
        bus_write(3'd4, 32'h3, 4'h1);
        check("m1_busy", {31'd0, busy}, 32'd1);
        check("m1_fwd",  {31'd0, fwd},  32'd1);
        wait_idle("m1", 400);
        check_move("m1");
        read_check("m1_position",  3'd6, 32'd5);
        read_check("m1_remaining", 3'd7, 32'd0);
        read_check("m1_status",    3'd5, 32'h2);
        check("m1_irq", {31'd0, irq}, 32'd0);

        // move 2: symmetric ramp 100 -> 40 -> 100
        clear_mon();
        bus_write(3'd0, 32'd10, 4'hF);
        bus_write(3'd1, 32'd100, 4'hF);
        bus_write(3'd2, 32'd40, 4'hF);
        bus_write(3'd3, 32'd20, 4'hF);
        exp_q = '{32'd100, 32'd80, 32'd60, 32'd40, 32'd40, 32'd40, 32'd40, 32'd60, 32'd80, 32'd100};
        bus_write(3'd4, 32'h3, 4'h1);
        wait_idle("m2", 1500);
        check_move("m2");
        read_check("m2_position", 3'd6, 32'd15);
        read_check("m2_status",   3'd5, 32'h2);

        // move 3: periods below the floor, reverse direction, position wraps
        clear_mon();
        bus_write(3'd6, 32'd0, 4'hF);
        bus_write(3'd0, 32'd3, 4'hF);
        bus_write(3'd1, 32'd2, 4'hF);
        bus_write(3'd2, 32'd2, 4'hF);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'd16);
        bus_write(3'd4, 32'h1, 4'h1);
        check("m3_fwd", {31'd0, fwd}, 32'd0);
        wait_idle("m3", 400);
        check_move("m3");
        read_check("m3_position", 3'd6, 32'hFFFF_FFFD);

        // move 4: abort two clocks into step 3 of 8
        clear_mon();
        bus_write(3'd0, 32'd8, 4'hF);
        bus_write(3'd1, 32'd20, 4'hF);
        bus_write(3'd2, 32'd20, 4'hF);
        bus_write(3'd4, 32'h3, 4'h1);
        wait_rises("m4", 3, 300);
        bus_write(3'd4, 32'h6, 4'h1);
        wait_idle("m4", 50);
        idle_cycles(60);
        check("m4_pulse_count", 32'(rise_q.size()), 32'd3);
        check("m4_last_width", (hw_q.size() == 3) ? 32'(hw_q[2]) : 32'hFFFF_FFFF, 32'(PULSE_W));
        read_check("m4_status",    3'd5, 32'h4);
        read_check("m4_remaining", 3'd7, 32'd5);
        read_check("m4_position",  3'd6, 32'd0);

        // move 5: zero-step start raises irq; status write clears it
        clear_mon();
        bus_write(3'd0, 32'd0, 4'hF);
        bus_write(3'd4, 32'h9, 4'h1);
        idle_cycles(5);
        check("m5_no_pulse", 32'(rise_q.size()), 32'd0);
        check("m5_busy", {31'd0, busy}, 32'd0);
        check("m5_irq",  {31'd0, irq},  32'd1);
        read_check("m5_status", 3'd5, 32'h2);
        bus_write(3'd5, 32'd0, 4'hF);
        check("m5_irq_clr", {31'd0, irq}, 32'd0);
        read_check("m5_status_clr", 3'd5, 32'h0);

        // move 6: restart and position write while busy are ignored
        clear_mon();
        bus_write(3'd0, 32'd4, 4'hF);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd20);
        bus_write(3'd4, 32'hB, 4'h1);
        check("m6_busy", {31'd0, busy}, 32'd1);
        read_check("m6_status_busy", 3'd5, 32'h1);
        bus_write(3'd6, 32'h0000_1234, 4'hF);
        bus_write(3'd0, 32'd100, 4'hF);
        bus_write(3'd4, 32'hB, 4'h1);
        wait_idle("m6", 400);
        check_move("m6");
        read_check("m6_position",  3'd6, 32'd4);
        read_check("m6_remaining", 3'd7, 32'd0);
        read_check("m6_status",    3'd5, 32'h2);
        check("m6_irq", {31'd0, irq}, 32'd1);

        // reset in the middle of a high phase
        clear_mon();
        bus_write(3'd4, 32'h3, 4'h1);
        wait_rises("rst", 1, 50);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fwd",  {31'd0, fwd},  32'd0);
        check("rst_irq",  {31'd0, irq},  32'd0);
        rst = 1'b0;
        read_check("rst_steps",    3'd0, 32'd0);
        read_check("rst_position", 3'd6, 32'd0);
        idle_cycles(30);
        check("rst_no_more_pulses", 32'(rise_q.size()), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_motor_sequencer.md
Name: step_motor_sequencer

Overview:
Avalon-MM controlled motion sequencer that drives the step/forward_back inputs of the step motor driver. Software loads a move (step count, direction, start/cruise periods, ramp delta) and starts it. The block emits a timed step pulse train with a linear period ramp (accelerate, cruise, decelerate), tracks absolute position and reports busy/done/aborted. It sits on the same MCLK domain as the driver's register interface.

Parameters:
PULSE_W, 4, step pulse high time in clocks
MIN_PERIOD, 16, hard floor for any step period in clocks; must be >= 2*PULSE_W

Ports:
csi_MCLK_clk  in  1  system clock
rsi_MRST_reset  in  1  synchronous active-high reset
avs_ctrl_writedata  in  32  register write data
avs_ctrl_readdata  out  32  register read data
avs_ctrl_byteenable  in  4  byte lanes for writes
avs_ctrl_address  in  3  word address
avs_ctrl_write  in  1  write strobe
avs_ctrl_read  in  1  read strobe
avs_ctrl_waitrequest  out  1  tied 0
step  out  1  step pulse to driver; rising edge = one step
forward_back  out  1  direction to driver; 1 = forward
busy  out  1  move in progress
irq  out  1  level; done_sticky & irq_en

Behaviour:
- One clock, csi_MCLK_clk; reset is synchronous and active-high on rsi_MRST_reset. Reset: all registers 0, state IDLE, step=0, forward_back=0, busy=0, irq=0, readdata=0.
- Register map (word addr): 0 STEPS (u32, byte-enabled); 1 P_START (u32); 2 P_CRUISE (u32); 3 P_DELTA (u32); 4 CTRL: bit0 start (write-1 pulse, reads 0), bit1 dir, bit2 abort (write-1 pulse), bit3 irq_en; 5 STATUS (RO): bit0 busy, bit1 done_sticky, bit2 aborted_sticky; any write to 5 clears bits 1-2; 6 POSITION (s32, writable only when IDLE, ignored when busy); 7 REMAINING (RO).
- Reads: readdata registered, valid the cycle after avs_ctrl_read. Write has priority over a simultaneous read. waitrequest always 0.
- Effective period: P_eff = max(value, MIN_PERIOD) for both P_START and P_CRUISE. If P_CRUISE > P_START, cruise = P_START (no ramp).
- FSM states: IDLE, PULSE_HI, PULSE_LO, STOP.
- IDLE: on start: latch dir into forward_back, REMAINING<=STEPS, cur_period<=P_eff(P_START), ramp_cnt<=0, clear done/aborted stickies. If STEPS==0, set done_sticky, stay IDLE, no pulse. Otherwise go to PULSE_HI next cycle, busy=1.
- PULSE_HI: step=1 for exactly PULSE_W clocks. On entry: POSITION +/-1 per direction (wraps mod 2^32), REMAINING -1.
- PULSE_LO: step=0 until cur_period total clocks since the rising edge. At the end: if REMAINING==0, set done_sticky, go IDLE. Otherwise update cur_period, go PULSE_HI.
- Ramp update at each step boundary: if REMAINING <= ramp_cnt, decelerate: cur_period = min(cur_period+P_DELTA, P_START_eff), ramp_cnt-1 (saturate at 0). Else if cur_period > cruise, accelerate: cur_period = max(cur_period-P_DELTA, cruise), ramp_cnt+1. Else cruise: hold. Arithmetic is 33-bit with saturation, no wrap.
- Abort in any non-IDLE state: go to STOP. STOP finishes the current high time (step is never truncated below PULSE_W), then goes IDLE with aborted_sticky=1, done_sticky unchanged at 0. Abort in IDLE is ignored.
- Start while busy is ignored. Writes to STEPS and period registers while busy take effect only on the next start; the move uses values latched at start.
- Start and abort in the same write: abort wins if busy; otherwise start.
- busy=1 from the cycle after an accepted start until the cycle IDLE is re-entered.
- Reset mid-move: step=0 immediately on the next edge and all state is cleared.

Test Plan:
- Reset, then read addrs 0-7 -> all 0; step=0, busy=0, irq=0.
- STEPS=5, P_START=P_CRUISE=20, dir=1, start -> 5 pulses, each 4 clk high with 20-clk rising-edge spacing; POSITION=5, REMAINING=0, STATUS=0x2, busy falls after the last period.
- STEPS=10, P_START=100, P_CRUISE=40, P_DELTA=20 -> periods 100,80,60,40,40,40,40,60,80,100 (symmetric ramp); end POSITION=15.
- P_START=2 (below MIN_PERIOD), STEPS=3, dir=0, from POSITION=0 -> spacing 16 clk; POSITION=0xFFFFFFFD.
- Abort written 2 clocks into step 3 of STEPS=8 -> the pulse stays high the full 4 clk, no further pulses; STATUS=0x4; REMAINING=5.
- STEPS=0 start with irq_en=1 -> no pulse, done_sticky=1, irq=1; write STATUS -> irq=0. Start while busy and write POSITION while busy -> both ignored.
